data_cache_wb: RTL and testbench
================================

# data_cache_wb

Parametrised direct-mapped write-back data cache between the memory stage and main memory. It replaces the single-cycle tag-check data cache. It adds loads and stores, dirty-line eviction, and a miss state machine with a request/acknowledge handshake to memory. The memory stage is stalled until each access completes.

## Interface
Parameters:
- NUM_LINES, 4: number of cache lines; power of two ≥2. INDEX_BITS = log2(NUM_LINES).
- LINE_WORDS, 4: 32-bit words per line; power of two ≥1. OFFSET_BITS = log2(LINE_WORDS)+2 (byte address).
- ADDR_WIDTH, 32: byte address width. TAG_BITS = ADDR_WIDTH − INDEX_BITS − OFFSET_BITS.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req  in  1  access request; held with addr/we/wdata until cpu_ready.
- cpu_we  in  1  1 = store word, 0 = load word.
- cpu_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data; valid when cpu_ready=1.
- cpu_ready  out  1  access completes this cycle.
- cpu_miss  out  1  request pending and not completing; memory stage stalls.
- mem_req  out  1  memory transaction request, held until mem_ack.
- mem_we  out  1  1 = line writeback, 0 = line fill.
- mem_addr  out  ADDR_WIDTH  line-aligned address; low OFFSET_BITS are zero.
- mem_wline  out  32*LINE_WORDS  writeback line; word 0 in bits [31:0].
- mem_rline  in  32*LINE_WORDS  fill line; sampled on mem_ack.
- mem_ack  in  1  single-cycle completion pulse.

## Operation
- Per line the cache holds: data, tag, valid, dirty. Reset clears all valid and dirty bits. Data and tags are not reset.
- Address split: tag = addr[ADDR_WIDTH−1 -: TAG_BITS], index = addr[OFFSET_BITS +: INDEX_BITS], word = addr[OFFSET_BITS−1:2].
- hit = cpu_req & valid[index] & (tag[index] == tag).
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE, hit:
  - cpu_ready=1.
  - Load: cpu_rdata is the selected word, combinationally.
  - Store: the word is written and dirty[index] is set on this edge.
- IDLE, miss:
  - Victim line valid and dirty: go to WRITEBACK.
  - Otherwise: go to REFILL.
- WRITEBACK:
  - Outputs: mem_req=1, mem_we=1, mem_addr={victim tag, index, 0}, mem_wline=victim data.
  - On mem_ack: clear dirty[index], go to REFILL.
- REFILL:
  - Outputs: mem_req=1, mem_we=0, mem_addr={cpu tag, index, 0}.
  - On mem_ack: write mem_rline, the tag and valid=1, dirty=0; go to IDLE.
  - The held request then hits in IDLE. A store merges at that point.
- cpu_miss = cpu_req & ~cpu_ready.
- mem_ack is ignored in IDLE.
- cpu_req deasserting outside IDLE is illegal; the bench must not do it.
- Reset values: state IDLE, cpu_ready=0, cpu_miss=0, mem_req=0, mem_we=0. mem_addr, mem_wline and cpu_rdata are 0 while in IDLE with no request.

## Timing
- Hit: zero-wait; cpu_ready in the same cycle as cpu_req. Store data is visible to a load in the next cycle.
- Clean miss: the miss is detected in cycle N, and mem_req is asserted from N+1. mem_ack arrives in cycle M, and cpu_ready follows in M+1.
- Dirty miss: WRITEBACK with mem_ack, then REFILL starting the next cycle with mem_ack, then cpu_ready the cycle after that.
- mem_ack in the same cycle mem_req first rises is legal and is accepted.
- mem_req, mem_we and mem_addr are decoded from state and stable for the whole transaction.
- Reset asserted mid-transaction:
  - The next edge returns to IDLE and drops mem_req.
  - No line, tag or valid bit is written from an aborted refill.
  - A concurrent mem_ack is discarded.
- Back-to-back hits: one access per cycle.

## Configuration
- DCACHE_STATS_EN defined: adds output ports hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count increments on every cycle with cpu_ready=1.
  - miss_count increments on every IDLE→WRITEBACK or IDLE→REFILL transition.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Test plan
- Cold read: after reset, load 0x00000010 with memory returning line {4,3,2,1} after 3 cycles. Expect:
  - mem_req=1, mem_we=0, mem_addr=0x10 while waiting.
  - cpu_rdata=1 and cpu_ready=1 one cycle after mem_ack.
  - A second load of 0x14 returns 2 with zero wait.
- Store hit: store 0xDEADBEEF to 0x18 on the resident line, then load 0x18. Expect:
  - cpu_ready in the same cycle for both accesses.
  - The load returns 0xDEADBEEF.
  - No mem_req.
- Dirty eviction: after the store test, load 0x00000050 (same index 1, new tag). Expect:
  - WRITEBACK first with mem_we=1, mem_addr=0x10, mem_wline={4,0xDEADBEEF,2,1}.
  - Then REFILL with mem_addr=0x50.
  - Then cpu_ready.
- Clean eviction: load 0x10 again over a clean line 0x50. Expect only REFILL (mem_we never 1) with mem_addr=0x10.
- Reset mid-refill: assert reset during REFILL with mem_ack coincident. Expect:
  - mem_req=0 the next cycle.
  - A following load of the same address misses again.
- DCACHE_STATS_EN: the cold-read sequence above yields hit_count=2 and miss_count=1. Without the macro the bench compiles without those ports.

Source files
------------

// File: rtl/data_cache_wb.sv
// Direct-mapped write-back data cache with a line-granular request/ack memory port.
// Optional DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module data_cache_wb #(
  parameter int NUM_LINES  = 4,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_WIDTH-1:0]    cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_ready,
  output logic                     cpu_miss,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [32*LINE_WORDS-1:0] mem_wline,
  input  logic [32*LINE_WORDS-1:0] mem_rline,
  input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int INDEX_BITS  = $clog2(NUM_LINES);
  localparam int OFFSET_BITS = $clog2(LINE_WORDS) + 2;
  localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
  localparam int LINE_BITS   = 32 * LINE_WORDS;
  localparam int WORD_BITS   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;
  state_t state_reg, state_next;

  logic [LINE_BITS-1:0] line_mem [NUM_LINES];
  logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_reg;
  logic [NUM_LINES-1:0] dirty_reg;

  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [WORD_BITS-1:0]  addr_word;
  logic [LINE_BITS-1:0]  cur_line;
  logic [TAG_BITS-1:0]   cur_tag;
  logic [LINE_BITS-1:0]  store_line;
  logic [31:0]           cur_words [LINE_WORDS];
  logic                  hit;
  logic                  store_hit;
  logic                  unused_addr_bits;

  assign addr_tag         = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign addr_index       = cpu_addr[OFFSET_BITS +: INDEX_BITS];
  assign unused_addr_bits = ^cpu_addr[1:0];

  generate
    if (LINE_WORDS > 1) begin : g_word_sel
      assign addr_word = cpu_addr[OFFSET_BITS-1:2];
    end else begin : g_word_one
      assign addr_word = '0;
    end
  endgenerate

  assign cur_line = line_mem[addr_index];
  assign cur_tag  = tag_mem[addr_index];

  // Store merge builds the whole new line so the array takes one write per edge.
  generate
    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_words
      assign cur_words[gi] = cur_line[gi*32 +: 32];
      assign store_line[gi*32 +: 32] =
        (addr_word == WORD_BITS'(gi)) ? cpu_wdata : cur_line[gi*32 +: 32];
    end
  endgenerate

  assign hit       = cpu_req & valid_reg[addr_index] & (cur_tag == addr_tag);
  assign store_hit = (state_reg == IDLE) & hit & cpu_we;
  assign cpu_miss  = cpu_req & ~cpu_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      valid_reg <= '0;
      dirty_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (store_hit)
        dirty_reg[addr_index] <= 1'b1;
      if (state_reg == WRITEBACK && mem_ack)
        dirty_reg[addr_index] <= 1'b0;
      if (state_reg == REFILL && mem_ack) begin
        valid_reg[addr_index] <= 1'b1;
        dirty_reg[addr_index] <= 1'b0;
      end
    end
  end

  // Data and tags carry no reset; gating writes on reset keeps aborted refills out.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (store_hit)
        line_mem[addr_index] <= store_line;
      if (state_reg == REFILL && mem_ack) begin
        line_mem[addr_index] <= mem_rline;
        tag_mem[addr_index]  <= addr_tag;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wline  = '0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = cur_words[addr_word];
        end else if (cpu_req) begin
          state_next = (valid_reg[addr_index] & dirty_reg[addr_index]) ? WRITEBACK : REFILL;
        end
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {cur_tag, addr_index, {OFFSET_BITS{1'b0}}};
        mem_wline = cur_line;
        if (mem_ack)
          state_next = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {addr_tag, addr_index, {OFFSET_BITS{1'b0}}};
        if (mem_ack)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (cpu_ready && hit_count != 32'hFFFF_FFFF)
        hit_count <= hit_count + 32'd1;
      if (state_reg == IDLE && state_next != IDLE && miss_count != 32'hFFFF_FFFF)
        miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache_wb.sv
// Directed bench for data_cache_wb: cold fill, store hit, dirty/clean eviction,
// back-to-back hits and reset during a refill.
module tb_data_cache_wb;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         cpu_miss;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wline;
  logic [127:0] mem_rline = '0;
  logic         mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int compared = 0;
  int mismatched = 0;

  data_cache_wb dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_miss(cpu_miss),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wline(mem_wline), .mem_rline(mem_rline), .mem_ack(mem_ack)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge (input drive point).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge (output sample point).
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    smp();
    compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", cpu_ready); end
    compared++; if (cpu_miss !== 1'b0) begin mismatched++; $display("FAIL reset_miss got %b want 0", cpu_miss); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    compared++; if (cpu_rdata !== 32'h0) begin mismatched++; $display("FAIL reset_rdata got %h want 0", cpu_rdata); end
    compared++; if (mem_wline !== 128'h0) begin mismatched++; $display("FAIL reset_wline got %h want 0", mem_wline); end
    $display("reset done");
  endtask

  task automatic test_cold_read();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    smp();
    compared++; if (cpu_miss !== 1'b1) begin mismatched++; $display("FAIL cold_miss got %b want 1", cpu_miss); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL cold_req_n got %b want 0", mem_req); end
    for (int i = 0; i < 2; i++) begin
      cyc(); smp();
      compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL cold_req got %b want 1", mem_req); end
      compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL cold_we got %b want 0", mem_we); end
      compared++; if (mem_addr !== 32'h10) begin mismatched++; $display("FAIL cold_addr got %h want 10", mem_addr); end
    end
    cyc(); mem_ack = 1'b1; mem_rline = {32'd4, 32'd3, 32'd2, 32'd1};
    smp();
    compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("FAIL cold_ready_ack got %b want 0", cpu_ready); end
    cyc(); mem_ack = 1'b0;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL cold_ready got %b want 1", cpu_ready); end
    compared++; if (cpu_rdata !== 32'd1) begin mismatched++; $display("FAIL cold_rdata got %h want 1", cpu_rdata); end
    $display("load 0x10 (cold) data=%h", cpu_rdata);
    cyc(); cpu_addr = 32'h14;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL hit14_ready got %b want 1", cpu_ready); end
    compared++; if (cpu_rdata !== 32'd2) begin mismatched++; $display("FAIL hit14_rdata got %h want 2", cpu_rdata); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL hit14_req got %b want 0", mem_req); end
    $display("load 0x14 (hit) data=%h", cpu_rdata);
    cyc(); cpu_req = 1'b0;
    smp();
    compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("FAIL idle_ready got %b want 0", cpu_ready); end
`ifdef DCACHE_STATS_EN
    compared++; if (hit_count !== 32'd2) begin mismatched++; $display("FAIL hit_count got %0d want 2", hit_count); end
    compared++; if (miss_count !== 32'd1) begin mismatched++; $display("FAIL miss_count got %0d want 1", miss_count); end
`endif
  endtask

  task automatic test_store_hit();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h18; cpu_wdata = 32'hDEADBEEF;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL st_ready got %b want 1", cpu_ready); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL st_req got %b want 0", mem_req); end
    $display("store 0x18 data=deadbeef");
    cyc(); cpu_we = 1'b0;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL ld18_ready got %b want 1", cpu_ready); end
    compared++; if (cpu_rdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL ld18_rdata got %h want deadbeef", cpu_rdata); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL ld18_req got %b want 0", mem_req); end
    $display("load 0x18 data=%h", cpu_rdata);
    cyc(); cpu_req = 1'b0;
  endtask

  task automatic test_dirty_evict();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h50;
    smp();
    compared++; if (cpu_miss !== 1'b1) begin mismatched++; $display("FAIL de_miss got %b want 1", cpu_miss); end
    cyc(); mem_ack = 1'b1;
    smp();
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL wb_req got %b want 1", mem_req); end
    compared++; if (mem_we !== 1'b1) begin mismatched++; $display("FAIL wb_we got %b want 1", mem_we); end
    compared++; if (mem_addr !== 32'h10) begin mismatched++; $display("FAIL wb_addr got %h want 10", mem_addr); end
    compared++; if (mem_wline !== {32'd4, 32'hDEADBEEF, 32'd2, 32'd1}) begin mismatched++; $display("FAIL wb_line got %h want 00000004deadbeef0000000200000001", mem_wline); end
    cyc(); mem_rline = {32'h5C, 32'h58, 32'h54, 32'h50};
    smp();
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL rf50_we got %b want 0", mem_we); end
    compared++; if (mem_addr !== 32'h50) begin mismatched++; $display("FAIL rf50_addr got %h want 50", mem_addr); end
    compared++; if (cpu_ready !== 1'b0) begin mismatched++; $display("FAIL rf50_ready got %b want 0", cpu_ready); end
    cyc(); mem_ack = 1'b0;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL de_ready got %b want 1", cpu_ready); end
    compared++; if (cpu_rdata !== 32'h50) begin mismatched++; $display("FAIL de_rdata got %h want 50", cpu_rdata); end
    $display("load 0x50 (dirty evict) data=%h", cpu_rdata);
    cyc(); cpu_req = 1'b0;
  endtask

  task automatic test_clean_evict();
    cyc(); cpu_req = 1'b1; cpu_addr = 32'h10;
    smp();
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL ce_req_n got %b want 0", mem_req); end
    cyc(); mem_ack = 1'b1; mem_rline = {32'd4, 32'hDEADBEEF, 32'd2, 32'd1};
    smp();
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL ce_req got %b want 1", mem_req); end
    compared++; if (mem_we !== 1'b0) begin mismatched++; $display("FAIL ce_we got %b want 0", mem_we); end
    compared++; if (mem_addr !== 32'h10) begin mismatched++; $display("FAIL ce_addr got %h want 10", mem_addr); end
    cyc(); mem_ack = 1'b0;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL ce_ready got %b want 1", cpu_ready); end
    compared++; if (cpu_rdata !== 32'd1) begin mismatched++; $display("FAIL ce_rdata got %h want 1", cpu_rdata); end
    $display("load 0x10 (clean evict) data=%h", cpu_rdata);
    cyc(); cpu_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'd1; exp_data[1] = 32'd2; exp_data[2] = 32'hDEADBEEF; exp_data[3] = 32'h12345678;
    cyc(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h1C; cpu_wdata = 32'h12345678;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_st_ready got %b want 1", cpu_ready); end
    $display("store 0x1c data=12345678");
    for (int i = 0; i < 4; i++) begin
      cyc(); cpu_we = 1'b0; cpu_addr = 32'h10 + 32'(i * 4);
      smp();
      compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready[%0d] got %b want 1", i, cpu_ready); end
      compared++; if (cpu_rdata !== exp_data[i]) begin mismatched++; $display("FAIL b2b_rdata[%0d] got %h want %h", i, cpu_rdata, exp_data[i]); end
      $display("load 0x%h data=%h", cpu_addr, cpu_rdata);
    end
    cyc(); cpu_req = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    cyc(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hA0;
    smp();
    cyc();
    smp();
    compared++; if (mem_addr !== 32'hA0) begin mismatched++; $display("FAIL rm_addr got %h want a0", mem_addr); end
    cyc(); reset = 1'b1; mem_ack = 1'b1; mem_rline = {4{32'hBAD0BAD0}};
    smp();
    cyc(); reset = 1'b0; mem_ack = 1'b0;
    smp();
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rm_req_drop got %b want 0", mem_req); end
    compared++; if (cpu_miss !== 1'b1) begin mismatched++; $display("FAIL rm_remiss got %b want 1", cpu_miss); end
    cyc(); mem_ack = 1'b1; mem_rline = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    smp();
    compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL rm_req2 got %b want 1", mem_req); end
    compared++; if (mem_addr !== 32'hA0) begin mismatched++; $display("FAIL rm_addr2 got %h want a0", mem_addr); end
    cyc(); mem_ack = 1'b0;
    smp();
    compared++; if (cpu_ready !== 1'b1) begin mismatched++; $display("FAIL rm_ready got %b want 1", cpu_ready); end
    compared++; if (cpu_rdata !== 32'hA0) begin mismatched++; $display("FAIL rm_rdata got %h want a0", cpu_rdata); end
    $display("load 0xa0 (after aborted refill) data=%h", cpu_rdata);
    cyc(); cpu_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_store_hit();
    test_dirty_evict();
    test_clean_evict();
    test_back_to_back();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
